bsg_counter_set_down_sched: RTL and testbench

//  Time-shares one bsg_counter_set_down among els_p requesters that each need a

---
 rtl/bsg_counter_sched_pkg.sv | 23 ++
 rtl/bsg_counter_set_down.sv | 41 ++++
 rtl/bsg_counter_set_down_sched.sv | 135 +++++++++++++
 tb/tb_bsg_counter_set_down_sched.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bsg_counter_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_counter_sched_pkg
//  Description : Shared definitions for the round-robin scheduled down-counter.
//                Holds the FSM state encoding and the helper that sizes the
//                owner/grant index.
//  Revision    : 1.0  initial release
// ============================================================================
package bsg_counter_sched_pkg;

  // FSM state encoding: IDLE waits for a request, COUNT runs a delay.
  typedef logic [0:0] sched_state_t;
  localparam sched_state_t c_state_idle  = 1'b0;
  localparam sched_state_t c_state_count = 1'b1;

  // Width of the owner index. A single requester still gets a 1-bit index
  // so owner_o never collapses to a zero-width port.
  function automatic int owner_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage : bsg_counter_sched_pkg
`default_nettype wire

// File: rtl/bsg_counter_set_down.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_counter_set_down
//  Description : Loadable down-counter. A load (set_i) takes priority over a
//                decrement (down_i). Arithmetic is modulo 2^width_p; the
//                caller is responsible for never decrementing from zero.
//  Ports       : clk_i      clock
//                reset_i    synchronous active-high reset, clears the count
//                set_i      load val_i this cycle
//                val_i      value to load
//                down_i     decrement by one this cycle
//                count_r_o  registered counter value
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_counter_set_down #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               set_i,
  input  logic [width_p-1:0] val_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_r_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (set_i) begin
      r_count <= val_i;
    end else if (down_i) begin
      r_count <= r_count - width_p'(1);
    end
  end

  assign count_r_o = r_count;

endmodule : bsg_counter_set_down
`default_nettype wire

// File: rtl/bsg_counter_set_down_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_counter_set_down_sched
//  Description : Time-shares one bsg_counter_set_down among els_p requesters.
//                A round-robin arbiter grants one request, loads its delay,
//                counts down to zero and pulses that requester's done line.
//  Ports       : clk_i    clock
//                reset_i  synchronous active-high reset
//                v_i      per-requester request valid
//                delay_i  per-requester delay, slice [i*width_p +: width_p]
//                yumi_o   one-hot accept of a request (combinational)
//                done_o   one-hot, 1-cycle pulse when the owner's delay expires
//                abort_i  cancel the delay in progress without a done pulse
//                busy_o   a delay is in progress
//                owner_o  index of the current / last grantee
//                count_o  shared counter value
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_counter_set_down_sched
  import bsg_counter_sched_pkg::*;
#(
  parameter int els_p   = 4,
  parameter int width_p = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [els_p-1:0]               v_i,
  input  logic [els_p*width_p-1:0]       delay_i,
  output logic [els_p-1:0]               yumi_o,
  output logic [els_p-1:0]               done_o,
  input  logic                           abort_i,
  output logic                           busy_o,
  output logic [owner_width(els_p)-1:0]  owner_o,
  output logic [width_p-1:0]             count_o
);

  localparam int c_ow = owner_width(els_p);

  sched_state_t       r_state;
  logic [c_ow-1:0]    r_last;
  logic [c_ow-1:0]    r_owner;

  logic [width_p-1:0] w_delay [els_p];
  logic [width_p-1:0] w_count;
  logic [width_p-1:0] w_val;
  logic [c_ow-1:0]    w_grant;
  logic               w_found;
  int                 w_idx;
  logic [els_p-1:0]   w_onehot_grant;
  logic [els_p-1:0]   w_onehot_owner;
  logic               w_busy;
  logic               w_zero;
  logic               w_abort;
  logic               w_window;
  logic               w_arb;
  logic               w_done;
  logic               w_set;
  logic               w_down;

  // Unpack the flat delay bus into one word per requester.
  for (genvar i = 0; i < els_p; i++) begin : g_unpack
    assign w_delay[i] = delay_i[i*width_p +: width_p];
  end

  // Round-robin search starting just after the last grantee.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = 0;
    for (int k = 1; k <= els_p; k++) begin
      w_idx = (int'(r_last) + k) % els_p;
      if (!w_found && (|(v_i & (els_p'(1) << w_idx)))) begin
        w_found = 1'b1;
        w_grant = c_ow'(w_idx);
      end
    end
  end

  always_comb begin
    w_onehot_grant          = '0;
    w_onehot_grant[w_grant] = 1'b1;
    w_onehot_owner          = '0;
    w_onehot_owner[r_owner] = 1'b1;
  end

  assign w_busy   = (r_state == c_state_count);
  assign w_zero   = (w_count == '0);
  // Abort only has meaning while a delay runs; in IDLE it is ignored.
  assign w_abort  = ~reset_i & abort_i & w_busy;
  // Arbitration happens in IDLE or in the cycle the running delay expires.
  assign w_window = ~w_busy | w_zero;
  assign w_arb    = ~reset_i & ~w_abort & w_window & w_found;
  // Abort beats done when both land in the same cycle.
  assign w_done   = ~reset_i & w_busy & w_zero & ~abort_i;

  assign w_set    = w_arb | w_abort;
  assign w_val    = w_arb ? w_delay[w_grant] : '0;
  // Gating on non-zero keeps the counter from wrapping.
  assign w_down   = w_busy & ~w_zero;

  bsg_counter_set_down #(
    .width_p (width_p)
  ) u_counter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .set_i     (w_set),
    .val_i     (w_val),
    .down_i    (w_down),
    .count_r_o (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= c_state_idle;
      r_last  <= c_ow'(els_p - 1);  // so index 0 wins the first arbitration
      r_owner <= '0;
    end else if (w_abort) begin
      r_state <= c_state_idle;
    end else if (w_arb) begin
      r_state <= c_state_count;
      r_last  <= w_grant;
      r_owner <= w_grant;
    end else if (w_done) begin
      r_state <= c_state_idle;
    end
  end

  assign yumi_o  = w_arb  ? w_onehot_grant : '0;
  assign done_o  = w_done ? w_onehot_owner : '0;
  assign busy_o  = w_busy;
  assign owner_o = r_owner;
  assign count_o = w_count;

endmodule : bsg_counter_set_down_sched
`default_nettype wire

// File: tb/tb_bsg_counter_set_down_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsg_counter_set_down_sched
//  Description : Directed, table-driven bench for bsg_counter_set_down_sched
//                (els_p=4, width_p=32). Each record is one clock cycle of
//                inputs plus the outputs expected during that cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bsg_counter_set_down_sched;

  localparam int c_els   = 4;
  localparam int c_width = 32;

  logic                       clk_i = 1'b0;
  logic                       reset_i = 1'b1;
  logic [c_els-1:0]           v_i = '0;
  logic [c_els*c_width-1:0]   delay_i = '0;
  logic [c_els-1:0]           yumi_o;
  logic [c_els-1:0]           done_o;
  logic                       abort_i = 1'b0;
  logic                       busy_o;
  logic [1:0]                 owner_o;
  logic [c_width-1:0]         count_o;

  bsg_counter_set_down_sched #(
    .els_p   (c_els),
    .width_p (c_width)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .delay_i (delay_i),
    .yumi_o  (yumi_o),
    .done_o  (done_o),
    .abort_i (abort_i),
    .busy_o  (busy_o),
    .owner_o (owner_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         chk;
    logic         rst;
    logic [3:0]   v;
    logic         abort;
    logic [127:0] dly;
    logic [3:0]   yumi;
    logic [3:0]   done;
    logic         busy;
    logic [1:0]   owner;
    logic [31:0]  cnt;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int n_step = 0;

  function automatic logic [127:0] dl(input logic [31:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic chk, rst, input logic [3:0] v,
                              input logic abort, input logic [127:0] dly,
                              input logic [3:0] yumi, done, input logic busy,
                              input logic [1:0] owner, input logic [31:0] cnt);
    vec_t x;
    x.chk = chk; x.rst = rst; x.v = v; x.abort = abort; x.dly = dly;
    x.yumi = yumi; x.done = done; x.busy = busy; x.owner = owner; x.cnt = cnt;
    return x;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h want %h", name, n_step, act, exp);
    end
  endtask

  // Drive on the falling edge, check 2 time units later (well clear of the
  // rising edge) so both combinational and registered outputs are settled.
  task automatic step(input vec_t x);
    @(negedge clk_i);
    reset_i = x.rst;
    v_i     = x.v;
    abort_i = x.abort;
    delay_i = x.dly;
    #2;
    if (x.chk) begin
      cmp("yumi",  32'(yumi_o),  32'(x.yumi));
      cmp("done",  32'(done_o),  32'(x.done));
      cmp("busy",  32'(busy_o),  32'(x.busy));
      cmp("owner", 32'(owner_o), 32'(x.owner));
      cmp("count", count_o,      x.cnt);
    end
    n_step++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    vec_t tbl[$];
    logic [127:0] d;

    // Reset, then single request from 0 with delay 3.
    d = dl(0, 0, 0, 3);
    tbl.push_back(mk(0, 1, 4'b0000, 0, d, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'b0000, 0, d, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0001, 0, d, 4'b0001, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, d, 4'b0000, 4'b0000, 1, 0, 3));
    tbl.push_back(mk(1, 0, 4'b0000, 0, d, 4'b0000, 4'b0000, 1, 0, 2));
    tbl.push_back(mk(1, 0, 4'b0000, 0, d, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(mk(1, 0, 4'b0000, 0, d, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, d, 4'b0000, 4'b0000, 0, 0, 0));

    // All requesting with zero delays: grants rotate 0,1,2,3,0 back to back.
    d = dl(0, 0, 0, 0);
    tbl.push_back(mk(1, 1, 4'b1111, 0, d, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 0, d, 4'b0001, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 0, d, 4'b0010, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 0, d, 4'b0100, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 0, d, 4'b1000, 4'b0100, 1, 2, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 0, d, 4'b0001, 4'b1000, 1, 3, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, d, 4'b0000, 4'b0001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 4'b0000, 0, d, 4'b0000, 4'b0000, 0, 0, 0));

    foreach (tbl[i]) step(tbl[i]);

    // Reset mid-count: requester 2 (delay 7) is granted, reset lands while
    // count_o=7; afterwards index 0 wins first.
    step(mk(1, 0, 4'b0100, 0, dl(0, 7, 0, 0), 4'b0100, 4'b0000, 0, 0, 0));
    step(mk(1, 1, 4'b0000, 0, dl(0, 7, 0, 0), 4'b0000, 4'b0000, 1, 2, 7));
    step(mk(1, 0, 4'b1111, 0, dl(0, 0, 0, 0), 4'b0001, 4'b0000, 0, 0, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 0, 0), 4'b0000, 4'b0001, 1, 0, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 0, 0), 4'b0000, 4'b0000, 0, 0, 0));

    // Abort mid-count: delay 5 on requester 0, aborted at count 3; the next
    // grant goes to requester 1 because last_r stays 0.
    step(mk(1, 0, 4'b0001, 0, dl(0, 0, 2, 5), 4'b0001, 4'b0000, 0, 0, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 2, 5), 4'b0000, 4'b0000, 1, 0, 5));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 2, 5), 4'b0000, 4'b0000, 1, 0, 4));
    step(mk(1, 0, 4'b0000, 1, dl(0, 0, 2, 5), 4'b0000, 4'b0000, 1, 0, 3));
    step(mk(1, 0, 4'b0011, 0, dl(0, 0, 2, 5), 4'b0010, 4'b0000, 0, 0, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 2, 5), 4'b0000, 4'b0000, 1, 1, 2));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 2, 5), 4'b0000, 4'b0000, 1, 1, 1));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 2, 5), 4'b0000, 4'b0010, 1, 1, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 2, 5), 4'b0000, 4'b0000, 0, 1, 0));

    // Abort in the done cycle: done suppressed and no grant even with all
    // requesting; arbitration resumes next cycle from last_r=2 -> index 3.
    step(mk(1, 0, 4'b0100, 0, dl(0, 1, 0, 0), 4'b0100, 4'b0000, 0, 1, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 1, 0, 0), 4'b0000, 4'b0000, 1, 2, 1));
    step(mk(1, 0, 4'b1111, 1, dl(0, 1, 0, 0), 4'b0000, 4'b0000, 1, 2, 0));
    step(mk(1, 0, 4'b1111, 0, dl(0, 1, 0, 0), 4'b1000, 4'b0000, 0, 2, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 1, 0, 0), 4'b0000, 4'b1000, 1, 3, 0));

    // Abort in IDLE is ignored: the grant to 0 still happens, loading the
    // all-ones delay, which is then aborted after two counting cycles.
    step(mk(1, 0, 4'b0001, 1, dl(0, 0, 0, 32'hFFFF_FFFF), 4'b0001, 4'b0000, 0, 3, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 0, 0), 4'b0000, 4'b0000, 1, 0, 32'hFFFF_FFFF));
    step(mk(1, 0, 4'b0000, 1, dl(0, 0, 0, 0), 4'b0000, 4'b0000, 1, 0, 32'hFFFF_FFFE));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 0, 0), 4'b0000, 4'b0000, 0, 0, 0));
    step(mk(1, 0, 4'b0000, 0, dl(0, 0, 0, 0), 4'b0000, 4'b0000, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bsg_counter_set_down_sched
`default_nettype wire
